tone_sequencer: RTL and testbench

Programmable frequency-step scheduler that drives the NCO's tuning-word input (step / step enable) ahead of the MASH 1-1 modulator and mod2 output stage. A small table of {step, dwell} entries is loaded over an AXI-stream config port. On `start` the table is played in order, each step held for its dwell count of accepted cycles, optionally looping. This gives the DAC chain multi-tone and sweep stimulus without testbench or CPU intervention.

---
 rtl/tone_seq_pkg.sv | 21 ++
 rtl/tone_sequencer_if.sv | 11 +
 rtl/tone_seq_table.sv | 26 ++
 rtl/tone_sequencer.sv | 149 ++++++++++++++
 tb/tb_tone_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and default widths for the tone sequencer and its table.
package tone_seq_pkg;

    localparam int TS_ACC_W   = 32;
    localparam int TS_DWELL_W = 24;
    localparam int TS_DEPTH   = 8;
    localparam int TS_IDX_W   = $clog2(TS_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tone_seq_state_e;

    // Field order matches the config word: dwell in the upper bits, step below.
    typedef struct packed {
        logic [TS_DWELL_W-1:0] dwell;
        logic [TS_ACC_W-1:0]   step;
    } tone_seq_entry_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// AXI-stream style data/valid/ready bundle; used for both the config and the step streams.
interface tone_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/tone_seq_table.sv
// Entry register file: one write port, one combinational read port.
// Latency: write visible the cycle after the write edge; read is same-cycle.
// Backpressure: none, the owner gates writes.
module tone_seq_table #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 8
) (
    input  logic                     aclk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/tone_sequencer.sv
// Plays a loaded table of {step, dwell} entries onto the NCO step stream.
// Latency: start to first valid step is one cycle; entries follow back-to-back.
// Backpressure: step output holds and dwell freezes while tready is low.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int ACC_WIDTH   = TS_ACC_W,
    parameter int DWELL_WIDTH = TS_DWELL_W,
    parameter int DEPTH       = TS_DEPTH
) (
    input  logic                     aclk,
    input  logic                     arst_n,
    tone_sequencer_if.slave          s_axis_cfg,
    tone_sequencer_if.master         m_axis_step,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     loop_en,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH)-1:0] entry_idx
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int ENT_W = ACC_WIDTH + DWELL_WIDTH;

    tone_seq_state_e        state;
    logic [CNT_W-1:0]       count;
    logic [IDX_W-1:0]       idx;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [ACC_WIDTH-1:0]   step_q;
    logic                   step_vld_q;
    logic                   cfg_rdy_q;

    logic                   cfg_hs;
    logic                   step_hs;
    logic                   wr_en;
    logic                   last;
    logic [CNT_W-1:0]       count_nxt;
    logic [IDX_W-1:0]       rd_addr;
    logic [ENT_W-1:0]       rd_dat;
    logic [ACC_WIDTH-1:0]   rd_step;
    logic [DWELL_WIDTH-1:0] rd_dwell;
    logic [DWELL_WIDTH-1:0] rd_dwell_eff;

    assign cfg_hs    = s_axis_cfg.tvalid && cfg_rdy_q;
    assign step_hs   = step_vld_q && m_axis_step.tready;
    assign wr_en     = cfg_hs && !clear && (state == ST_IDLE);
    assign count_nxt = clear ? '0 : (wr_en ? count + CNT_W'(1) : count);

    // The wrap point is the loaded count, not the table depth.
    assign last    = ({1'b0, idx} == (count - CNT_W'(1)));
    assign rd_addr = ((state == ST_RUN) && !last) ? idx + IDX_W'(1) : '0;

    tone_seq_table #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_table (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (count[IDX_W-1:0]),
        .wr_dat  (s_axis_cfg.tdata),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    assign rd_step      = rd_dat[ACC_WIDTH-1:0];
    assign rd_dwell     = rd_dat[ENT_W-1:ACC_WIDTH];
    assign rd_dwell_eff = (rd_dwell == '0) ? DWELL_WIDTH'(1) : rd_dwell;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            idx        <= '0;
            dwell_cnt  <= '0;
            step_q     <= '0;
            step_vld_q <= 1'b0;
            cfg_rdy_q  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    count <= count_nxt;
                    if (start && !stop && !clear && (count != '0)) begin
                        state      <= ST_RUN;
                        idx        <= '0;
                        dwell_cnt  <= rd_dwell_eff;
                        step_q     <= rd_step;
                        step_vld_q <= 1'b1;
                        busy       <= 1'b1;
                        cfg_rdy_q  <= 1'b0;
                    end else begin
                        err       <= start && !stop;
                        cfg_rdy_q <= (count_nxt < CNT_W'(DEPTH));
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state      <= ST_IDLE;
                        idx        <= '0;
                        dwell_cnt  <= '0;
                        step_q     <= '0;
                        step_vld_q <= 1'b0;
                        busy       <= 1'b0;
                        cfg_rdy_q  <= (count < CNT_W'(DEPTH));
                    end else if (step_hs) begin
                        if (dwell_cnt == DWELL_WIDTH'(1)) begin
                            if (last && !loop_en) begin
                                state      <= ST_DONE;
                                dwell_cnt  <= '0;
                                step_q     <= '0;
                                step_vld_q <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end else begin
                                idx       <= last ? '0 : idx + IDX_W'(1);
                                dwell_cnt <= rd_dwell_eff;
                                step_q    <= rd_step;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    idx       <= '0;
                    cfg_rdy_q <= (count < CNT_W'(DEPTH));
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_cfg.tready  = cfg_rdy_q;
    assign m_axis_step.tdata  = step_q;
    assign m_axis_step.tvalid = step_vld_q;
    assign entry_idx          = idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed and randomized playback checks against an expanded-sequence model.
module tb_tone_sequencer;
    import tone_seq_pkg::*;

    localparam int AW = TS_ACC_W;
    localparam int DW = TS_DWELL_W;
    localparam int EW = AW + DW;
    localparam int IW = TS_IDX_W;

    logic          aclk    = 1'b0;
    logic          arst_n  = 1'b0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          clear   = 1'b0;
    logic          loop_en = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] entry_idx;

    int vectors     = 0;
    int miscompares = 0;

    tone_seq_entry_t mdl[$];

    tone_sequencer_if #(.WIDTH(EW)) cfg ();
    tone_sequencer_if #(.WIDTH(AW)) stp ();

    tone_sequencer #(
        .ACC_WIDTH   (AW),
        .DWELL_WIDTH (DW),
        .DEPTH       (TS_DEPTH)
    ) dut (
        .aclk        (aclk),
        .arst_n      (arst_n),
        .s_axis_cfg  (cfg),
        .m_axis_step (stp),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .loop_en     (loop_en),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .entry_idx   (entry_idx)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_tvalid"}, stp.tvalid, 0);
        chk({tag, "_tdata"},  stp.tdata, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
    endtask

    task automatic load(input logic [DW-1:0] d, input logic [AW-1:0] s);
        tone_seq_entry_t e;
        e.dwell = d;
        e.step  = s;
        chk("cfg_tready", cfg.tready, mdl.size() < TS_DEPTH);
        cfg.tdata  = e;
        cfg.tvalid = 1'b1;
        tick();
        cfg.tvalid = 1'b0;
        if (mdl.size() < TS_DEPTH) mdl.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mdl.delete();
        chk("clear_tready", cfg.tready, 1);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_quiet("stop");
        tick();
        chk("stop_no_done", done, 0);
    endtask

    // rdy_mode: 0 = always ready, 1 = 1,0,1,0..., 2 = random
    task automatic play(input bit loop, input int max_cyc, input int rdy_mode,
                        input bit stop_last, input bit clr);
        logic [AW-1:0] es[$];
        int            ei[$];
        int            pos;
        int            reps;
        bit            rdy;
        foreach (mdl[e]) begin
            reps = (mdl[e].dwell == 0) ? 1 : int'(mdl[e].dwell);
            for (int r = 0; r < reps; r++) begin
                es.push_back(mdl[e].step);
                ei.push_back(e);
            end
        end
        loop_en = loop;
        start   = 1'b1;
        tick();
        start = 1'b0;
        clear = clr;
        pos   = 0;
        for (int c = 0; c < max_cyc; c++) begin
            chk("run_tvalid", stp.tvalid, 1);
            chk("run_tdata",  stp.tdata, es[pos]);
            chk("run_idx",    entry_idx, ei[pos]);
            chk("run_busy",   busy, 1);
            chk("run_done",   done, 0);
            chk("run_cfg_tready", cfg.tready, 0);
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            stp.tready = rdy;
            stop = stop_last && rdy && (pos == es.size() - 1);
            tick();
            if (stop) begin
                stop  = 1'b0;
                clear = 1'b0;
                chk_quiet("stop_last");
                tick();
                chk("stop_last_no_done", done, 0);
                stp.tready = 1'b1;
                return;
            end
            if (rdy) pos++;
            if (pos == es.size()) begin
                if (loop) begin
                    pos = 0;
                end else begin
                    clear = 1'b0;
                    chk("fin_done",   done, 1);
                    chk("fin_tvalid", stp.tvalid, 0);
                    chk("fin_tdata",  stp.tdata, 0);
                    chk("fin_busy",   busy, 0);
                    tick();
                    chk("fin_done_clr", done, 0);
                    chk("fin_idle_tready", cfg.tready, mdl.size() < TS_DEPTH);
                    stp.tready = 1'b1;
                    return;
                end
            end
        end
        clear = 1'b0;
        stp.tready = 1'b1;
        if (!loop) chk("finish_in_budget", pos, es.size());
    endtask

    initial begin
        int n;
        cfg.tvalid = 1'b0;
        cfg.tdata  = '0;
        stp.tready = 1'b1;

        #1;
        chk_quiet("reset");
        chk("reset_err", err, 0);
        chk("reset_idx", entry_idx, 0);
        chk("reset_cfg_tready", cfg.tready, 0);
        tick();
        arst_n = 1'b1;
        tick();
        chk("post_reset_tready", cfg.tready, 1);

        // Start with nothing loaded
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_err", err, 1);
        chk_quiet("empty");
        tick();
        chk("empty_err_clr", err, 0);

        // Load and play
        load(24'd5, 32'h0040_0000);
        load(24'd3, 32'd85900);
        play(1'b0, 20, 0, 1'b0, 1'b0);

        // Loop three times then stop
        play(1'b1, 24, 0, 1'b0, 1'b0);
        stop_pulse();
        loop_en = 1'b0;

        // Back-pressure
        do_clear();
        load(24'd4, 32'h0012_3456);
        play(1'b0, 20, 1, 1'b0, 1'b0);

        // Zero dwell, then clear held during run
        do_clear();
        load(24'd0, 32'h0000_aaaa);
        load(24'd2, 32'h0000_bbbb);
        load(24'd0, 32'h0000_cccc);
        play(1'b0, 20, 0, 1'b0, 1'b0);
        play(1'b0, 20, 0, 1'b0, 1'b1);
        play(1'b0, 60, 2, 1'b0, 1'b0);

        // stop together with start in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk_quiet("stop_start");
        chk("stop_start_err", err, 0);
        tick();
        chk("stop_start_tvalid2", stp.tvalid, 0);

        // stop on last-entry expiry
        play(1'b0, 20, 0, 1'b1, 1'b0);

        // Fill the table; the ninth write must be refused
        do_clear();
        for (int i = 0; i < TS_DEPTH + 1; i++) load(DW'($urandom_range(0, 3)), $urandom());
        play(1'b0, 200, 2, 1'b0, 1'b0);

        // Randomized tables
        for (int it = 0; it < 6; it++) begin
            do_clear();
            n = $urandom_range(1, TS_DEPTH);
            for (int i = 0; i < n; i++) load(DW'($urandom_range(0, 5)), $urandom());
            if (it % 3 == 2) begin
                play(1'b1, 40, 2, 1'b0, 1'b0);
                stop_pulse();
                loop_en = 1'b0;
            end else begin
                play(1'b0, 300, 2, 1'b0, 1'b0);
            end
        end

        // Reset mid-run
        do_clear();
        load(24'd5, 32'h0040_0000);
        load(24'd3, 32'd85900);
        play(1'b1, 7, 0, 1'b0, 1'b0);
        loop_en = 1'b0;
        arst_n  = 1'b0;
        #1;
        chk_quiet("midrst");
        chk("midrst_idx", entry_idx, 0);
        chk("midrst_cfg_tready", cfg.tready, 0);
        mdl.delete();
        #1;
        arst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midrst_err", err, 1);
        chk("midrst_tvalid", stp.tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
